// File: rtl/dmi_async_queue_source_if.sv
// Handshake and crossing bundle between the DTM-side enqueue logic and the queue sink.
// The slave modport is the queue source. The master modport is its environment.
interface dmi_async_queue_source_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 41
);
  localparam int AW = $clog2(DEPTH) + 1;

  logic                   enq_valid;
  logic                   enq_ready;
  logic [WIDTH-1:0]       enq_bits;
  logic [DEPTH*WIDTH-1:0] async_mem;
  logic [AW-1:0]          async_widx;
  logic [AW-1:0]          async_ridx;
  logic                   async_source_valid;
  logic                   async_sink_valid;

  modport slave (
    input  enq_valid, enq_bits, async_ridx, async_sink_valid,
    output enq_ready, async_mem, async_widx, async_source_valid
  );

  modport master (
    output enq_valid, enq_bits, async_ridx, async_sink_valid,
    input  enq_ready, async_mem, async_widx, async_source_valid
  );
endinterface

// File: rtl/dmi_async_queue_source.sv
// Enqueue half of the DTM->DM async request queue. It publishes the register file
// and a Gray write index, and it consumes the sink's Gray read index.
module dmi_aqs_sync #(
  parameter int W      = 1,
  parameter int STAGES = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] d_out
);
  logic [STAGES-1:0][W-1:0] chain_q, chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d_in};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) chain_q <= '0;
    else          chain_q <= chain_d;
  end

  assign d_out = chain_q[STAGES-1];
endmodule

module dmi_async_queue_source #(
  parameter int DEPTH       = 8,
  parameter int WIDTH       = 41,
  parameter int SYNC_STAGES = 3
) (
  input  logic                       clock,
  input  logic                       reset_n,
  dmi_async_queue_source_if.slave    q
);
  localparam int AW = $clog2(DEPTH) + 1;
  localparam int IW = AW - 1;
  // Full when the Gray indices differ in exactly the top two bits.
  localparam logic [AW-1:0] FULL_MASK = AW'(3) << (AW - 2);

  function automatic logic [AW-1:0] bin2gray(input logic [AW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [AW-1:0] ridx_s;
  logic          sink_ok;

  dmi_aqs_sync #(.W(AW), .STAGES(SYNC_STAGES)) u_ridx_sync (
    .clock(clock), .reset_n(reset_n), .d_in(q.async_ridx), .d_out(ridx_s)
  );

  dmi_aqs_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sink_sync (
    .clock(clock), .reset_n(reset_n), .d_in(q.async_sink_valid), .d_out(sink_ok)
  );

  logic [AW-1:0]                widx_bin_q, widx_bin_d;
  logic [AW-1:0]                widx_gray_q, widx_gray_d;
  logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;
  logic                         src_valid_q, src_valid_d;
  logic                         full, ready, fire;

  always_comb begin
    full  = (widx_gray_q == (ridx_s ^ FULL_MASK));
    ready = sink_ok & ~full;
    fire  = q.enq_valid & ready;
  end

  always_comb begin
    widx_bin_d  = widx_bin_q;
    widx_gray_d = widx_gray_q;
    mem_d       = mem_q;
    src_valid_d = 1'b1;
    // Losing the sink rewinds the index; it re-handshakes from 0 and the entries are left untouched.
    if (!sink_ok) begin
      widx_bin_d  = '0;
      widx_gray_d = '0;
    end else if (fire) begin
      mem_d[widx_bin_q[IW-1:0]] = q.enq_bits;
      widx_bin_d                = widx_bin_q + 1'b1;
      widx_gray_d               = bin2gray(widx_bin_d);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      widx_bin_q  <= '0;
      widx_gray_q <= '0;
      mem_q       <= '0;
      src_valid_q <= 1'b0;
    end else begin
      widx_bin_q  <= widx_bin_d;
      widx_gray_q <= widx_gray_d;
      mem_q       <= mem_d;
      src_valid_q <= src_valid_d;
    end
  end

  assign q.enq_ready          = ready;
  assign q.async_mem          = mem_q;
  assign q.async_widx         = widx_gray_q;
  assign q.async_source_valid = src_valid_q;
endmodule
